gpio_bus_bridge: RTL and testbench

GPIO_BUS_BRIDGE -- requirements
Module: gpio_bus_bridge

---
 rtl/gpio_bus_bridge.sv | 118 +++++++++++
 tb/tb_gpio_bus_bridge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/gpio_bus_bridge.sv
// Bridges CPU memory-style requests onto a single 32-bit GPIO register window.
// Partial writes are read-modify-write; reads return registered data.
module gpio_bus_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_rbusy,
   output logic        mem_wbusy,
   output logic        gpio_wr_en,
   output logic        gpio_rd_en,
   output logic [31:0] gpio_wr_data,
   input  logic [31:0] gpio_rd_data
);

   // state  | meaning
   // IDLE   | waiting; the only state that samples requests
   // READ   | CPU read; word 0 strobes the GPIO register
   // RMW_RD | partial write, fetching current register contents
   // WRITE  | one-cycle write strobe with final data
   typedef enum logic [1:0] {IDLE, READ, RMW_RD, WRITE} state_t;

   state_t      state_q, state_d;
   logic        hit, word0, wr_req, rd_req, full_wr;
   logic [31:0] wdata_q;
   logic [3:0]  wmask_q;
   logic        rd_word0_q;
   logic [31:0] merged;
   logic        unused_addr_lsb;

   assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign word0   = (mem_addr[3:2] == 2'd0);
   // A nonzero mask always marks a write, so a colliding read strobe is dropped.
   assign wr_req  = hit && word0 && (mem_wmask != 4'd0);
   assign rd_req  = hit && mem_rstrb && (mem_wmask == 4'd0);
   assign full_wr = (mem_wmask == 4'hF);
   assign unused_addr_lsb = &{1'b0, mem_addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_req)      state_d = full_wr ? WRITE : RMW_RD;
            else if (rd_req) state_d = READ;
         end
         READ:    state_d = IDLE;
         RMW_RD:  state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_rbusy  = 1'b0;
      mem_wbusy  = 1'b0;
      gpio_rd_en = 1'b0;
      gpio_wr_en = 1'b0;
      case (state_q)
         READ: begin
            mem_rbusy  = 1'b1;
            gpio_rd_en = rd_word0_q;
         end
         RMW_RD: begin
            mem_wbusy  = 1'b1;
            gpio_rd_en = 1'b1;
         end
         WRITE: begin
            mem_wbusy  = 1'b1;
            gpio_wr_en = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      merged = gpio_rd_data;
      for (int b = 0; b < 4; b++) begin
         if (wmask_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // gpio_wr_data is loaded on entry to WRITE so it is stable for the strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wdata_q      <= '0;
         wmask_q      <= '0;
         rd_word0_q   <= 1'b0;
         mem_rdata    <= '0;
         gpio_wr_data <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_req) begin
                  wdata_q <= mem_wdata;
                  wmask_q <= mem_wmask;
                  if (full_wr) gpio_wr_data <= mem_wdata;
               end else if (rd_req) begin
                  rd_word0_q <= word0;
               end
            end
            READ:    mem_rdata    <= rd_word0_q ? gpio_rd_data : 32'd0;
            RMW_RD:  gpio_wr_data <= merged;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// Directed plus randomized bench for gpio_bus_bridge with a simple GPIO
// register attached and a request-level reference model.
module tb_gpio_bus_bridge;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, gpio_wr_data, gpio_rd_data;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, mem_rbusy, mem_wbusy, gpio_wr_en, gpio_rd_en;
   logic [31:0] gpio_reg = 32'd0;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_reg = 32'd0;
   logic [31:0] model_wr  = 32'd0;
   logic [31:0] model_rd  = 32'd0;

   gpio_bus_bridge #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy),
      .mem_wbusy(mem_wbusy), .gpio_wr_en(gpio_wr_en), .gpio_rd_en(gpio_rd_en),
      .gpio_wr_data(gpio_wr_data), .gpio_rd_data(gpio_rd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (gpio_wr_en) gpio_reg <= gpio_wr_data;
   assign gpio_rd_data = gpio_reg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status();
      return {28'd0, mem_rbusy, mem_wbusy, gpio_rd_en, gpio_wr_en};
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic rs);
      mem_addr  = a;
      mem_wdata = wd;
      mem_wmask = m;
      mem_rstrb = rs;
   endtask

   // Status words below are {rbusy, wbusy, rd_en, wr_en}.
   task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input logic rs, input bit junk);
      logic        hit;
      int          word;
      logic [31:0] wexp;
      logic [3:0]  seq[$];
      hit  = (a / 16) == (BASE / 16);
      word = int'((a % 16) / 4);
      wexp = model_wr;
      if (hit && m != 4'd0 && word == 0) begin
         for (int b = 0; b < 4; b++)
            wexp[8*b +: 8] = m[b] ? wd[8*b +: 8] : model_reg[8*b +: 8];
         if (m != 4'hF) seq.push_back(4'b0110);
         seq.push_back(4'b0101);
         model_reg = wexp;
         model_wr  = wexp;
      end else if (hit && m == 4'd0 && rs) begin
         seq.push_back(word == 0 ? 4'b1010 : 4'b1000);
         model_rd = (word == 0) ? model_reg : 32'd0;
      end
      @(negedge clk);
      drive(a, wd, m, rs);
      @(negedge clk);
      foreach (seq[i]) begin
         if (junk) drive(BASE, 32'hFFFF_FFFF, 4'h3, 1'b1);
         else      drive(32'd0, 32'd0, 4'd0, 1'b0);
         chk({tag, "_status"}, status(), {28'd0, seq[i]});
         if (seq[i][0]) chk({tag, "_wrdata"}, gpio_wr_data, wexp);
         @(negedge clk);
      end
      drive(32'd0, 32'd0, 4'd0, 1'b0);
      chk({tag, "_idle"}, status(), 32'd0);
      chk({tag, "_rdata"}, mem_rdata, model_rd);
      chk({tag, "_wrhold"}, gpio_wr_data, model_wr);
      chk({tag, "_reg"}, gpio_reg, model_reg);
   endtask

   initial begin
      logic [31:0] a, wd;
      logic [3:0]  m;
      logic        rs;
      int          sel;

      reset = 1'b1;
      drive(32'd0, 32'd0, 4'd0, 1'b0);
      #2;
      chk("reset_status", status(), 32'd0);
      chk("reset_rdata", mem_rdata, 32'd0);
      chk("reset_wrdata", gpio_wr_data, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_req("full_wr", BASE, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
      run_req("preload", BASE, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
      run_req("partial_wr", BASE, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
      chk("partial_value", model_reg, 32'h11BB_33DD);
      run_req("preload_a5", BASE, 32'h0000_00A5, 4'hF, 1'b0, 1'b0);
      run_req("read_w0", BASE, 32'd0, 4'd0, 1'b1, 1'b0);
      chk("read_w0_value", mem_rdata, 32'h0000_00A5);
      run_req("read_w1", BASE + 32'd4, 32'd0, 4'd0, 1'b1, 1'b0);
      run_req("wr_reserved", BASE + 32'd8, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
      run_req("read_w0_b", BASE, 32'd0, 4'd0, 1'b1, 1'b0);
      run_req("miss_wr", 32'h0050_0000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
      run_req("miss_rd", 32'h0050_0000, 32'd0, 4'd0, 1'b1, 1'b0);
      run_req("collision", BASE, 32'h5A5A_0101, 4'hF, 1'b1, 1'b0);
      run_req("b2b_busy", BASE, 32'h0F0F_0F0F, 4'b0011, 1'b0, 1'b1);
      run_req("b2b_retry", BASE, 32'hFFFF_FFFF, 4'h3, 1'b1, 1'b0);

      // Abort a partial write while it is fetching the register.
      @(negedge clk);
      drive(BASE, 32'h0000_0000, 4'b1000, 1'b0);
      @(negedge clk);
      drive(32'd0, 32'd0, 4'd0, 1'b0);
      chk("rst_mid_rmw_state", status(), 32'b0110);
      #1 reset = 1'b1;
      #1;
      chk("rst_async_status", status(), 32'd0);
      chk("rst_async_rdata", mem_rdata, 32'd0);
      chk("rst_async_wrdata", gpio_wr_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_wr = 32'd0;
      model_rd = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_resume", status(), 32'd0);
      end
      chk("rst_reg_kept", gpio_reg, model_reg);

      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 5);
         if (sel < 4)       a = BASE + 32'(4 * sel) + 32'($urandom_range(0, 3));
         else if (sel == 4) a = 32'h0050_0000 + 32'($urandom_range(0, 15));
         else               a = $urandom;
         case ($urandom_range(0, 3))
            0:       m = 4'd0;
            1:       m = 4'hF;
            default: m = 4'($urandom_range(1, 14));
         endcase
         rs = 1'($urandom_range(0, 1));
         wd = $urandom;
         run_req("rand", a, wd, m, rs, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
